// File: rtl/sm4_pkg.sv
// SM4 constants and round functions shared by the encryptor and decryptor.
// Holds the S-box, FK/CK constants, the controller state enum and the tau/L/L' helpers.
package sm4_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    EXPAND = 3'd2,
    ROUND  = 3'd3,
    DONE   = 3'd4
  } sm4_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  localparam logic [31:0] FK [4] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};

  localparam logic [31:0] CK [32] = '{
    32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
    32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
    32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
    32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
    32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
    32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
    32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
    32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
  };

  function automatic logic [31:0] tau(input logic [31:0] a);
    return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
  endfunction

  // L for the data path: rotations by 2, 10, 18 and 24
  function automatic logic [31:0] l_data(input logic [31:0] b);
    return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
  endfunction

  // L' for the key schedule: rotations by 13 and 23
  function automatic logic [31:0] l_key(input logic [31:0] b);
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  function automatic logic [31:0] t_data(input logic [31:0] a);
    return l_data(tau(a));
  endfunction

  function automatic logic [31:0] t_key(input logic [31:0] a);
    return l_key(tau(a));
  endfunction

endpackage

// File: rtl/sm4_key_expand.sv
// SM4 iterative key schedule: one round key per step, 32 steps after load; rk store with async read.
// No backpressure: the controller owns load/step timing and reads rk[31-j] during decryption rounds.
module sm4_key_expand
  import sm4_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [127:0] mk,
  input  logic [4:0]   rd_idx,
  output logic [31:0]  rk_rd,
  output logic         last
);

  logic [127:0] k_reg;
  logic [4:0]   cnt;
  logic [31:0]  rk_mem [32];
  logic [31:0]  rk_new;

  assign rk_new = k_reg[127:96] ^ t_key(k_reg[95:64] ^ k_reg[63:32] ^ k_reg[31:0] ^ CK[cnt]);
  assign last   = (cnt == 5'd31);
  assign rk_rd  = rk_mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_reg <= '0;
      cnt   <= '0;
      for (int i = 0; i < 32; i++) begin
        rk_mem[i] <= '0;
      end
    end else if (load) begin
      k_reg <= mk ^ {FK[0], FK[1], FK[2], FK[3]};
      cnt   <= '0;
    end else if (step) begin
      // K window slides by one word; the new word is rk[cnt]
      k_reg       <= {k_reg[95:0], rk_new};
      rk_mem[cnt] <= rk_new;
      cnt         <= cnt + 5'd1;
    end
  end

endmodule

// File: rtl/sm4_decrypt_top.sv
// SM4 block decryptor: 4-word load, 32-cycle key expand, 32 rounds, 1-cycle DONE (68 cycles, 36 on key-cache hit).
// Stalls the core via HOLD_PIPLINE while busy; VALID_IN ignored outside IDLE/LOAD. Optional key cache: SM4_KEY_CACHE_EN.
module sm4_decrypt_top
  import sm4_pkg::*;
(
  input  logic         CLK,
  input  logic         REST,
  input  logic         VALID_IN,
  input  logic [31:0]  MESSAGE,
  input  logic [31:0]  INITIAL_KEY,
  output logic         HOLD_PIPLINE,
  output logic         SAVE_DATA,
  output logic [127:0] RESULT_31
);

  sm4_state_t   state, next_state;
  logic [1:0]   load_cnt;
  logic [4:0]   rnd_cnt;
  logic [127:0] msg_reg;
  logic [95:0]  key_reg;
  logic [127:0] full_key;
  logic         capture, last_word, key_load, cache_hit, key_last;
  logic         expand_step, hold_nxt, save_nxt;
  logic [4:0]   rd_idx;
  logic [31:0]  rk_rd, x_new;

  assign capture     = VALID_IN && ((state == IDLE) || (state == LOAD));
  assign last_word   = VALID_IN && (state == LOAD) && (load_cnt == 2'd3);
  assign full_key    = {key_reg, INITIAL_KEY};
  assign key_load    = last_word && !cache_hit;
  assign expand_step = (state == EXPAND);
  assign rd_idx      = 5'd31 - rnd_cnt;
  assign x_new       = msg_reg[127:96] ^ t_data(msg_reg[95:64] ^ msg_reg[63:32] ^ msg_reg[31:0] ^ rk_rd);

  sm4_key_expand u_key_expand (
    .clk    (CLK),
    .rst_n  (REST),
    .load   (key_load),
    .step   (expand_step),
    .mk     (full_key),
    .rd_idx (rd_idx),
    .rk_rd  (rk_rd),
    .last   (key_last)
  );

  always_ff @(posedge CLK or negedge REST) begin
    if (!REST) begin
      state        <= IDLE;
      HOLD_PIPLINE <= 1'b0;
      SAVE_DATA    <= 1'b0;
    end else begin
      state        <= next_state;
      HOLD_PIPLINE <= hold_nxt;
      SAVE_DATA    <= save_nxt;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (VALID_IN) next_state = LOAD;
      LOAD:    if (last_word) next_state = cache_hit ? ROUND : EXPAND;
      EXPAND:  if (key_last) next_state = ROUND;
      ROUND:   if (rnd_cnt == 5'd31) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state and registered, so they line up with the state
  always_comb begin
    hold_nxt = (next_state == LOAD) || (next_state == EXPAND) || (next_state == ROUND);
    save_nxt = (next_state == DONE);
  end

  always_ff @(posedge CLK or negedge REST) begin
    if (!REST) begin
      load_cnt  <= '0;
      rnd_cnt   <= '0;
      msg_reg   <= '0;
      key_reg   <= '0;
      RESULT_31 <= '0;
    end else begin
      if (capture) begin
        msg_reg  <= {msg_reg[95:0], MESSAGE};
        key_reg  <= {key_reg[63:0], INITIAL_KEY};
        load_cnt <= (state == IDLE) ? 2'd1 : load_cnt + 2'd1;
      end
      if (state == ROUND) begin
        // msg_reg holds the sliding window X[j..j+3], word j in the top bits
        msg_reg <= {msg_reg[95:0], x_new};
        rnd_cnt <= rnd_cnt + 5'd1;
        if (rnd_cnt == 5'd31) begin
          RESULT_31 <= {x_new, msg_reg[31:0], msg_reg[63:32], msg_reg[95:64]};
        end
      end else begin
        rnd_cnt <= '0;
      end
    end
  end

`ifdef SM4_KEY_CACHE_EN
  logic [127:0] cache_key;
  logic         cache_vld;

  // Key is captured when expansion starts but only trusted once all 32 rk are written
  always_ff @(posedge CLK or negedge REST) begin
    if (!REST) begin
      cache_key <= '0;
      cache_vld <= 1'b0;
    end else if (key_load) begin
      cache_key <= full_key;
      cache_vld <= 1'b0;
    end else if ((state == EXPAND) && key_last) begin
      cache_vld <= 1'b1;
    end
  end

  assign cache_hit = cache_vld && (full_key == cache_key);
`else
  assign cache_hit = 1'b0;
`endif

endmodule

// File: tb/tb_sm4_decrypt_top.sv
// Bench for sm4_decrypt_top: vector table plus random blocks against a block-level SM4 model,
// with hand sequences for held VALID_IN and reset in the middle of the rounds.
module tb_sm4_decrypt_top;
  import sm4_pkg::*;

`ifdef SM4_KEY_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         REST = 1'b0;
  logic         VALID_IN = 1'b0;
  logic [31:0]  MESSAGE = '0;
  logic [31:0]  INITIAL_KEY = '0;
  logic         HOLD_PIPLINE;
  logic         SAVE_DATA;
  logic [127:0] RESULT_31;

  int n_checks = 0;
  int n_fail   = 0;
  bit           model_cache_vld = 1'b0;
  logic [127:0] model_cache_key = '0;

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           gap;
  } vec_t;

  sm4_decrypt_top dut (
    .CLK          (CLK),
    .REST         (REST),
    .VALID_IN     (VALID_IN),
    .MESSAGE      (MESSAGE),
    .INITIAL_KEY  (INITIAL_KEY),
    .HOLD_PIPLINE (HOLD_PIPLINE),
    .SAVE_DATA    (SAVE_DATA),
    .RESULT_31    (RESULT_31)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] m_t(input logic [31:0] x, input bit key_sched);
    logic [31:0] b;
    for (int i = 0; i < 4; i++) b[8*i +: 8] = SBOX[x[8*i +: 8]];
    if (key_sched) return b ^ m_rotl(b, 13) ^ m_rotl(b, 23);
    return b ^ m_rotl(b, 2) ^ m_rotl(b, 10) ^ m_rotl(b, 18) ^ m_rotl(b, 24);
  endfunction

  // Whole-block SM4: dec=0 encrypts, dec=1 decrypts (round keys reversed)
  function automatic logic [127:0] m_sm4(input logic [127:0] key, input logic [127:0] blk, input bit dec);
    logic [31:0] k [36];
    logic [31:0] rk [32];
    logic [31:0] x [36];
    logic [31:0] fk [4];
    logic [31:0] ck;
    fk[0] = 32'ha3b1bac6; fk[1] = 32'h56aa3350; fk[2] = 32'h677d9197; fk[3] = 32'hb27022dc;
    for (int i = 0; i < 4; i++) begin
      k[i] = key[127-32*i -: 32] ^ fk[i];
      x[i] = blk[127-32*i -: 32];
    end
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'((4*i + j) * 7);
      k[i+4] = k[i] ^ m_t(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck, 1'b1);
      rk[i]  = k[i+4];
    end
    for (int i = 0; i < 32; i++) begin
      x[i+4] = x[i] ^ m_t(x[i+1] ^ x[i+2] ^ x[i+3] ^ rk[dec ? 31 - i : i], 1'b0);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Starts at a negedge with the DUT idle; word 0 is accepted by the next posedge (cycle 1 follows it)
  task automatic run_block(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] pt,
                           input int gap, input bit keep_valid);
    int lat, save_cyc, pulses;
    int d [4];
    bit hold_ok;
    lat = ((CACHE_ON && model_cache_vld && (model_cache_key == key)) ? 36 : 68) + gap;
    d[0] = 0; d[1] = 1; d[2] = 2 + gap; d[3] = 3 + gap;
    save_cyc = -1; pulses = 0; hold_ok = 1'b1;
    for (int c = 0; c <= lat + 3; c++) begin
      if (c > 0) begin
        @(negedge CLK);
        if (SAVE_DATA) begin
          pulses++;
          if (save_cyc < 0) save_cyc = c;
        end
        if ((c < lat) && (HOLD_PIPLINE !== 1'b1)) hold_ok = 1'b0;
        if ((c >= lat) && (HOLD_PIPLINE !== 1'b0)) hold_ok = 1'b0;
        if (c == lat) check("result", RESULT_31, pt);
      end
      VALID_IN    = 1'b0;
      MESSAGE     = $urandom();
      INITIAL_KEY = $urandom();
      for (int w = 0; w < 4; w++) begin
        if (c == d[w]) begin
          VALID_IN    = 1'b1;
          MESSAGE     = ct[127-32*w -: 32];
          INITIAL_KEY = key[127-32*w -: 32];
        end
      end
      if (keep_valid && (c > d[3]) && (c <= lat)) VALID_IN = 1'b1;
    end
    check_int("save_latency", save_cyc, lat);
    check_int("save_pulses", pulses, 1);
    check_int("hold_window", int'(hold_ok), 1);
    model_cache_vld = 1'b1;
    model_cache_key = key;
  endtask

  initial begin
    vec_t vecs [8];
    logic [127:0] k0, ct0, rt_pt, key, pt, ct;
    int rs, saw, hold_bad;

    k0    = 128'h0123456789abcdeffedcba9876543210;
    ct0   = 128'h681edf34d206965e86b3e94f536e4246;
    rt_pt = 128'h00112233445566778899aabbccddeeff;

    vecs[0] = '{key: k0, ct: ct0, pt: k0, gap: 0};
    vecs[1] = '{key: k0, ct: ct0, pt: k0, gap: 3};
    vecs[2] = '{key: k0, ct: m_sm4(k0, rt_pt, 1'b0), pt: rt_pt, gap: 0};
    for (int i = 3; i < 8; i++) begin
      key = (i == 4) ? vecs[3].key : rand128();
      pt  = rand128();
      vecs[i] = '{key: key, ct: m_sm4(key, pt, 1'b0), pt: pt, gap: int'($urandom_range(0, 3))};
    end

    repeat (3) @(negedge CLK);
    check("reset_hold", HOLD_PIPLINE, 0);
    check("reset_save", SAVE_DATA, 0);
    check("reset_result", RESULT_31, 0);
    REST = 1'b1;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 8; i++) begin
      run_block(vecs[i].key, vecs[i].ct, vecs[i].pt, vecs[i].gap, 1'b0);
    end

    // VALID_IN held high through EXPAND/ROUND/DONE with junk on the data lines
    run_block(k0, ct0, k0, 0, 1'b1);
    saw = 0; hold_bad = 0;
    for (int c = 0; c < 75; c++) begin
      @(negedge CLK);
      if (SAVE_DATA) saw++;
      if (HOLD_PIPLINE) hold_bad++;
    end
    check_int("held_valid_extra_save", saw, 0);
    check_int("held_valid_back_to_idle", hold_bad, 0);

    // Reset asserted during round 10
    key = rand128(); pt = rand128(); ct = m_sm4(key, pt, 1'b0);
    rs = (CACHE_ON && model_cache_vld && (model_cache_key == key)) ? 4 : 36;
    for (int w = 0; w < 4; w++) begin
      VALID_IN    = 1'b1;
      MESSAGE     = ct[127-32*w -: 32];
      INITIAL_KEY = key[127-32*w -: 32];
      @(negedge CLK);
    end
    VALID_IN = 1'b0;
    repeat (rs + 10 - 4) @(negedge CLK);
    check("busy_before_reset", HOLD_PIPLINE, 1);
    REST = 1'b0;
    #1;
    check("midrst_hold", HOLD_PIPLINE, 0);
    check("midrst_save", SAVE_DATA, 0);
    check("midrst_result", RESULT_31, 0);
    repeat (2) @(negedge CLK);
    REST = 1'b1;
    model_cache_vld = 1'b0;
    saw = 0; hold_bad = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge CLK);
      if (SAVE_DATA) saw++;
      if (HOLD_PIPLINE) hold_bad++;
    end
    check_int("post_reset_save", saw, 0);
    check_int("post_reset_hold", hold_bad, 0);
    check("post_reset_result", RESULT_31, 0);

    run_block(k0, ct0, k0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
